// File: rtl/alarm_sequencer.sv
// Alarm setpoint storage, arming, match detection and ring/snooze/auto-silence sequencing.
// Sits beside the timekeeper and feeds the display mux and buzzer driver.
module alarm_sequencer #(
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_TIMEOUT_S = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic [5:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    input  logic       alarm_set,
    input  logic       inc_hr,
    input  logic       inc_min,
    input  logic       arm_toggle,
    input  logic       snooze,
    input  logic       stop,
    output logic [5:0] alarm_hour,
    output logic [5:0] alarm_min,
    output logic       armed,
    output logic       ringing,
    output logic       snoozing,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        RING   = 3'd2,
        SNOOZE = 3'd3,
        SET    = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] hour_d, min_d;
    logic       armed_d;
    logic [5:0] wake_hour, wake_min, wake_hour_d, wake_min_d;
    logic [7:0] ring_cnt, ring_cnt_d;
    logic [6:0] snooze_sum;
    logic [5:0] snooze_hour, snooze_min;
    logic       alarm_match, wake_match;

    localparam logic [7:0] RING_LAST = 8'(RING_TIMEOUT_S - 1);

    assign alarm_match = tick_1hz && (cur_sec == 6'd0) &&
                         (cur_hour == alarm_hour) && (cur_min == alarm_min);
    assign wake_match  = tick_1hz && (cur_sec == 6'd0) &&
                         (cur_hour == wake_hour) && (cur_min == wake_min);

    // Wake target is "now + SNOOZE_MIN", carrying minute overflow into the hour.
    always_comb begin
        snooze_sum = {1'b0, cur_min} + 7'(SNOOZE_MIN);
        if (snooze_sum >= 7'd60) begin
            snooze_min  = 6'(snooze_sum - 7'd60);
            snooze_hour = (cur_hour == 6'd23) ? 6'd0 : cur_hour + 6'd1;
        end else begin
            snooze_min  = snooze_sum[5:0];
            snooze_hour = cur_hour;
        end
    end

    always_comb begin
        state_d     = state_q;
        hour_d      = alarm_hour;
        min_d       = alarm_min;
        armed_d     = armed;
        wake_hour_d = wake_hour;
        wake_min_d  = wake_min;
        ring_cnt_d  = ring_cnt;

        if (alarm_set) begin
            state_d = SET;
            if (state_q == SET) begin
                if (inc_hr)
                    hour_d = (alarm_hour == 6'd23) ? 6'd0 : alarm_hour + 6'd1;
                if (inc_min)
                    min_d = (alarm_min == 6'd59) ? 6'd0 : alarm_min + 6'd1;
            end
        end else begin
            case (state_q)
                SET: state_d = armed ? ARMED : IDLE;
                IDLE: begin
                    if (arm_toggle) begin
                        armed_d = 1'b1;
                        state_d = ARMED;
                    end
                end
                ARMED: begin
                    if (arm_toggle) begin
                        armed_d = 1'b0;
                        state_d = IDLE;
                    end else if (alarm_match) begin
                        state_d    = RING;
                        ring_cnt_d = 8'd0;
                    end
                end
                RING: begin
                    if (arm_toggle) begin
                        armed_d = 1'b0;
                        state_d = IDLE;
                    end else if (stop) begin
                        state_d = ARMED;
                    end else if (snooze) begin
                        state_d     = SNOOZE;
                        wake_hour_d = snooze_hour;
                        wake_min_d  = snooze_min;
                    end else if (tick_1hz) begin
                        ring_cnt_d = ring_cnt + 8'd1;
                        if (ring_cnt == RING_LAST)
                            state_d = ARMED;
                    end
                end
                SNOOZE: begin
                    if (arm_toggle) begin
                        armed_d = 1'b0;
                        state_d = IDLE;
                    end else if (stop) begin
                        state_d = ARMED;
                    end else if (wake_match) begin
                        state_d    = RING;
                        ring_cnt_d = 8'd0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Status flags are registered from the next state so they align with state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            alarm_hour <= 6'd0;
            alarm_min  <= 6'd0;
            armed      <= 1'b0;
            ringing    <= 1'b0;
            snoozing   <= 1'b0;
            wake_hour  <= 6'd0;
            wake_min   <= 6'd0;
            ring_cnt   <= 8'd0;
        end else begin
            state_q    <= state_d;
            alarm_hour <= hour_d;
            alarm_min  <= min_d;
            armed      <= armed_d;
            ringing    <= (state_d == RING);
            snoozing   <= (state_d == SNOOZE);
            wake_hour  <= wake_hour_d;
            wake_min   <= wake_min_d;
            ring_cnt   <= ring_cnt_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed self-checking bench for alarm_sequencer: setpoint editing, ringing,
// auto-silence, snooze with hour wrap, priorities and reset.
module tb_alarm_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1hz;
    logic [5:0] cur_hour, cur_min, cur_sec;
    logic       alarm_set, inc_hr, inc_min, arm_toggle, snooze, stop;
    logic [5:0] alarm_hour, alarm_min;
    logic       armed, ringing, snoozing;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    localparam int S_IDLE = 0, S_ARMED = 1, S_RING = 2, S_SNOOZE = 3, S_SET = 4;

    alarm_sequencer #(.SNOOZE_MIN(5), .RING_TIMEOUT_S(60)) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .alarm_set(alarm_set), .inc_hr(inc_hr), .inc_min(inc_min),
        .arm_toggle(arm_toggle), .snooze(snooze), .stop(stop),
        .alarm_hour(alarm_hour), .alarm_min(alarm_min), .armed(armed),
        .ringing(ringing), .snoozing(snoozing), .state(state)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkStatus(input string tag, input int st, input int rg, input int sn, input int ar);
        checkOutput({tag, ".state"}, int'(state), st);
        checkOutput({tag, ".ringing"}, int'(ringing), rg);
        checkOutput({tag, ".snoozing"}, int'(snoozing), sn);
        checkOutput({tag, ".armed"}, int'(armed), ar);
    endtask

    task automatic timeStep(input int h, input int m, input int s);
        cur_hour = 6'(h);
        cur_min  = 6'(m);
        cur_sec  = 6'(s);
        tick_1hz = 1'b1;
        applyStimulus();
        tick_1hz = 1'b0;
    endtask

    task automatic pulseArm();
        arm_toggle = 1'b1;
        applyStimulus();
        arm_toggle = 1'b0;
    endtask

    task automatic pulseIncs(input int hrs, input int mins);
        for (int i = 0; i < hrs; i++) begin
            inc_hr = 1'b1;
            applyStimulus();
            inc_hr = 1'b0;
        end
        for (int i = 0; i < mins; i++) begin
            inc_min = 1'b1;
            applyStimulus();
            inc_min = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b0;
        tick_1hz = 1'b0;
        cur_hour = 6'd0; cur_min = 6'd0; cur_sec = 6'd0;
        alarm_set = 1'b0; inc_hr = 1'b0; inc_min = 1'b0;
        arm_toggle = 1'b0; snooze = 1'b0; stop = 1'b0;
        applyStimulus();
        applyStimulus();
        checkStatus("reset", S_IDLE, 0, 0, 0);
        checkOutput("reset.hour", int'(alarm_hour), 0);
        checkOutput("reset.min", int'(alarm_min), 0);
        rst = 1'b1;

        // Edit setpoint to 07:30
        alarm_set = 1'b1;
        applyStimulus();
        pulseIncs(7, 30);
        checkOutput("set.hour", int'(alarm_hour), 7);
        checkOutput("set.min", int'(alarm_min), 30);
        checkOutput("set.state", int'(state), S_SET);
        alarm_set = 1'b0;
        applyStimulus();
        checkStatus("set_exit", S_IDLE, 0, 0, 0);

        // Arm, match, then auto-silence after 60 ticks
        pulseArm();
        checkStatus("arm", S_ARMED, 0, 0, 1);
        timeStep(7, 29, 59);
        checkStatus("pre_match", S_ARMED, 0, 0, 1);
        timeStep(7, 30, 0);
        checkStatus("match", S_RING, 1, 0, 1);
        for (int s = 1; s < 60; s++) begin
            timeStep(7, 30, s);
            applyStimulus();
        end
        checkStatus("ring_59", S_RING, 1, 0, 1);
        timeStep(7, 31, 0);
        checkStatus("autosilence", S_ARMED, 0, 0, 1);

        // inc_hr outside SET is ignored
        inc_hr = 1'b1;
        applyStimulus();
        inc_hr = 1'b0;
        checkOutput("inc_ignored", int'(alarm_hour), 7);

        // Move setpoint to 23:58 and snooze across midnight
        alarm_set = 1'b1;
        applyStimulus();
        pulseIncs(16, 28);
        checkOutput("set2.hour", int'(alarm_hour), 23);
        checkOutput("set2.min", int'(alarm_min), 58);
        alarm_set = 1'b0;
        applyStimulus();
        checkStatus("set2_exit", S_ARMED, 0, 0, 1);
        timeStep(23, 58, 0);
        checkStatus("ring2", S_RING, 1, 0, 1);
        cur_sec = 6'd10;
        snooze = 1'b1;
        applyStimulus();
        snooze = 1'b0;
        checkStatus("snooze", S_SNOOZE, 0, 1, 1);
        timeStep(0, 2, 0);
        checkStatus("pre_wake", S_SNOOZE, 0, 1, 1);
        timeStep(0, 3, 0);
        checkStatus("wake", S_RING, 1, 0, 1);
        stop = 1'b1;
        applyStimulus();
        stop = 1'b0;
        checkStatus("stop", S_ARMED, 0, 0, 1);

        // Simultaneous increments at 23:59 both wrap without carry
        alarm_set = 1'b1;
        applyStimulus();
        pulseIncs(0, 1);
        checkOutput("set3.min", int'(alarm_min), 59);
        inc_hr = 1'b1;
        inc_min = 1'b1;
        applyStimulus();
        inc_hr = 1'b0;
        inc_min = 1'b0;
        checkOutput("wrap.hour", int'(alarm_hour), 0);
        checkOutput("wrap.min", int'(alarm_min), 0);
        alarm_set = 1'b0;
        applyStimulus();
        checkStatus("set3_exit", S_ARMED, 0, 0, 1);

        // Midnight rollover fires a 00:00 setpoint
        timeStep(23, 59, 59);
        checkStatus("pre_midnight", S_ARMED, 0, 0, 1);
        timeStep(0, 0, 0);
        checkStatus("midnight", S_RING, 1, 0, 1);

        // stop beats snooze in the same cycle
        stop = 1'b1;
        snooze = 1'b1;
        applyStimulus();
        stop = 1'b0;
        snooze = 1'b0;
        checkStatus("stop_wins", S_ARMED, 0, 0, 1);

        // Reset mid-RING
        timeStep(0, 0, 0);
        checkStatus("ring3", S_RING, 1, 0, 1);
        rst = 1'b0;
        applyStimulus();
        checkStatus("rst_ring", S_IDLE, 0, 0, 0);
        checkOutput("rst_ring.hour", int'(alarm_hour), 0);
        checkOutput("rst_ring.min", int'(alarm_min), 0);
        rst = 1'b1;

        // Disarmed alarm stays silent on a match
        timeStep(0, 0, 0);
        checkStatus("disarmed_match", S_IDLE, 0, 0, 0);

        // Disarm while snoozing: wake target passes silently
        pulseArm();
        timeStep(0, 0, 0);
        checkStatus("ring4", S_RING, 1, 0, 1);
        cur_sec = 6'd5;
        snooze = 1'b1;
        applyStimulus();
        snooze = 1'b0;
        checkStatus("snooze2", S_SNOOZE, 0, 1, 1);
        pulseArm();
        checkStatus("snooze_disarm", S_IDLE, 0, 0, 0);
        timeStep(0, 5, 0);
        checkStatus("silent_wake", S_IDLE, 0, 0, 0);

        // Entering SET abandons RING
        pulseArm();
        timeStep(0, 0, 0);
        checkStatus("ring5", S_RING, 1, 0, 1);
        alarm_set = 1'b1;
        applyStimulus();
        checkStatus("set_abort", S_SET, 0, 0, 1);
        alarm_set = 1'b0;
        applyStimulus();
        checkStatus("set_abort_exit", S_ARMED, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
